// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the two byte producers, the write arbiter and
// the FIFO write port. The arbiter uses the slave modport; whatever drives
// the producers and models the FIFO uses the master modport.
interface fifo_wr_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       wr_fifo;
  logic [7:0] wr_data;
  logic       full;
  logic [1:0] gnt;

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output full,
    input  req0_ready, req1_ready, wr_fifo, wr_data, gnt
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  full,
    output req0_ready, req1_ready, wr_fifo, wr_data, gnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between two byte
// producers. A grant lasts until end of packet, a BURST-byte limit, or
// TIMEOUT consecutive cycles without owner valid. Ready and strobe are
// combinational so a full FIFO stalls the transfer in the same cycle.
module fifo_wr_arbiter #(
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned BW = $clog2(BURST + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST - 1);
  localparam logic [BW-1:0] BEAT_ONE = BW'(1);
  localparam logic [BW-1:0] BEAT_ZERO = BW'(0);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_ONE = IW'(1);
  localparam logic [IW-1:0] IDLE_ZERO = IW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_served_q, last_served_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [1:0]    gnt_q, gnt_d;

  logic       own_s;
  logic       owner_k_s;
  logic       owner_valid_s;
  logic       owner_last_s;
  logic [7:0] owner_data_s;
  logic       other_valid_s;
  logic       xfer_s;
  logic       timeout_s;
  logic       release_s;

  // Select the current owner's handshake signals and derive transfer/release.
  always_comb begin
    own_s     = 1'b0;
    owner_k_s = 1'b0;
    case (state_q)
      OWN0:    own_s = 1'b1;
      OWN1: begin
        own_s     = 1'b1;
        owner_k_s = 1'b1;
      end
      default: own_s = 1'b0;
    endcase
    owner_valid_s = owner_k_s ? bus.req1_valid : bus.req0_valid;
    owner_last_s  = owner_k_s ? bus.req1_last  : bus.req0_last;
    owner_data_s  = owner_k_s ? bus.req1_data  : bus.req0_data;
    other_valid_s = owner_k_s ? bus.req0_valid : bus.req1_valid;
    xfer_s        = own_s & owner_valid_s & ~bus.full;
    // The TIMEOUT-th consecutive valid-low cycle releases at its closing edge.
    timeout_s     = own_s & ~owner_valid_s & (idle_q == IDLE_MAX);
    release_s     = (xfer_s & (owner_last_s | (beat_q == BEAT_MAX))) | timeout_s;
  end

  // Next-state, round-robin choice and beat/idle counter updates.
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    beat_d        = beat_q;
    idle_d        = idle_q;
    case (state_q)
      IDLE: begin
        beat_d = BEAT_ZERO;
        idle_d = IDLE_ZERO;
        if (bus.req0_valid && bus.req1_valid) begin
          state_d = last_served_q ? OWN0 : OWN1;
        end else if (bus.req0_valid) begin
          state_d = OWN0;
        end else if (bus.req1_valid) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (release_s) begin
          last_served_d = owner_k_s;
          beat_d        = BEAT_ZERO;
          idle_d        = IDLE_ZERO;
          if (other_valid_s) begin
            state_d = owner_k_s ? OWN0 : OWN1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          // Full-stalled cycles have valid high: no beat, idle count cleared.
          if (xfer_s) begin
            beat_d = beat_q + BEAT_ONE;
          end else begin
            beat_d = beat_q;
          end
          if (owner_valid_s) begin
            idle_d = IDLE_ZERO;
          end else begin
            idle_d = idle_q + IDLE_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = BEAT_ZERO;
        idle_d  = IDLE_ZERO;
      end
    endcase
    gnt_d = {state_d == OWN1, state_d == OWN0};
  end

  // State, round-robin pointer, counters and registered grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      beat_q        <= BEAT_ZERO;
      idle_q        <= IDLE_ZERO;
      gnt_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      beat_q        <= beat_d;
      idle_q        <= idle_d;
      gnt_q         <= gnt_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.req0_ready = (state_q == OWN0) & ~bus.full;
  assign bus.req1_ready = (state_q == OWN1) & ~bus.full;
  assign bus.wr_fifo    = xfer_s;
  assign bus.wr_data    = xfer_s ? owner_data_s : 8'h00;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the RC4 byte FIFO between two producers (e.g. keystream generator and host byte loader). Each producer presents bytes over a valid/ready handshake; the arbiter grants one producer at a time, holds the grant for a packet or a bounded burst, and forwards accepted bytes to the FIFO write port while honouring the FIFO `full` flag. It sits directly in front of the FIFO `wr_fifo`/`wr_data`/`full` pins.

## Interface
- `BURST`, 4: maximum bytes accepted per grant before the grant is re-arbitrated (≥1).
- `TIMEOUT`, 8: consecutive cycles with owner `valid` low before the grant is revoked (≥1).

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  producer 0 has a byte.
- `req0_data`  in  8  producer 0 byte.
- `req0_last`  in  1  byte is the last of producer 0 packet.
- `req0_ready`  out  1  producer 0 byte accepted when high with `req0_valid`.
- `req1_valid`, `req1_data[7:0]`, `req1_last`, `req1_ready`: same as producer 0, for producer 1.
- `wr_fifo`  out  1  write strobe to FIFO; high exactly on transfer cycles.
- `wr_data`  out  8  byte to FIFO; 0 when `wr_fifo` low.
- `full`  in  1  FIFO full; no write strobe issued while high.
- `gnt`  out  2  one-hot current owner (bit k = producer k); 0 when idle.

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, `last_served` (1 bit), beat counter (`$clog2(BURST+1)` bits), idle counter (`$clog2(TIMEOUT+1)` bits).
- Reset: state IDLE, `last_served`=1 (producer 0 wins first tie), counters 0; outputs `gnt`=0, `req0_ready`=`req1_ready`=0, `wr_fifo`=0, `wr_data`=0.
- IDLE: both ready low. If exactly one `reqk_valid` high → OWNk. If both → OWN of producer ≠ `last_served`. Else stay. Counters cleared on entry to any OWN state.
- OWNk: `gnt`[k]=1; `reqk_ready` = !`full`; other producer ready = 0. Transfer = `reqk_valid` && !`full`; on transfer `wr_fifo`=1, `wr_data`=`reqk_data`, beat counter +1, idle counter cleared.
- Release condition in OWNk: transfer with `reqk_last`=1, or transfer with beat counter == BURST-1, or idle counter reaching TIMEOUT.
- On release: `last_served`←k. If other producer `valid` high that cycle → OWN(other) directly (counters cleared); else → IDLE.
- Idle counter: increments each OWN cycle with `reqk_valid`=0; cleared when valid high. Cycles stalled by `full` (valid high) never count toward timeout and never advance the beat counter.
- Ready/strobe are combinational from state, `full`, `reqk_valid`; no byte is ever written while `full`=1 and no byte is dropped or duplicated.
- Producer may deassert `valid` freely; a byte is consumed only on a transfer cycle.

## Timing
- Grant latency: 1 cycle from `reqk_valid` rising in IDLE to `gnt`/`reqk_ready` high.
- Throughput: 1 byte/cycle while owner valid and FIFO not full.
- Handover with other producer waiting: zero bubble; first byte of new owner may transfer the cycle after the releasing transfer.
- Release to IDLE, then new request: 1 bubble cycle.
- Timeout: grant revoked on the edge after the TIMEOUT-th consecutive valid-low cycle.
- `rst` asserted mid-burst: all outputs return to reset values immediately (asynchronously); partial burst abandoned; no `wr_fifo` pulse during or on the cycle after reset release.
- `full` toggling mid-burst: strobe follows `full` combinationally the same cycle; grant held.

## Test plan
- Reset, then `req0_valid`=1 with bytes 0x11,0x22,0x33 (`last` on 0x33), `full`=0 -> `gnt`=01 after 1 cycle, `wr_fifo` high 3 consecutive cycles with 0x11,0x22,0x33, then IDLE, `last_served`=0.
- Both producers valid continuously, no `last`, BURST=4 -> writes alternate 4 bytes req0, 4 bytes req1, repeat, zero bubble between groups.
- Owner req1 streaming, `full` held high 5 cycles mid-burst -> `wr_fifo`=0 and `req1_ready`=0 those 5 cycles, no timeout, burst resumes with next byte, total bytes written equals bytes offered.
- Owner req0 drops valid for 8 cycles (TIMEOUT=8) while req1 valid -> grant moves to req1 on edge after 8th idle cycle; no write during the gap.
- Simultaneous first requests after reset -> req0 granted first; after its release, simultaneous requests -> req1 granted.
- Assert `rst` during second byte of a burst -> `gnt`=0, `wr_fifo`=0 immediately; after release with req1 valid, arbitration restarts from IDLE with req0 priority tie-break.
